// File: rtl/seq_enc_pkg.sv
// rtl/seq_enc_pkg.sv - shared types and helpers for the sequential priority encoder
package seq_enc_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int N_DEF = 4;
  localparam int IDX_W = $clog2(N_DEF);

  // Inputs are zero-extended to 16 bits, the widest request vector supported.
  function automatic logic onehot_count_is_one(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/lsb_index_find.sv
// rtl/lsb_index_find.sv - combinational lowest-set-bit encoder with any-set flag
module lsb_index_find #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - multi-hot vector in, one index per beat out, lowest first
module seq_priority_encoder
  import seq_enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req,
  input  logic         flush,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         zero_seen
);

  state_t         state;
  logic [N-1:0]   pending;
  logic           alive;
  logic           pending_any;
  logic [N-1:0]   clear_mask;

  lsb_index_find #(.N(N), .W(W)) u_find (
    .vec (pending),
    .idx (idx),
    .any (pending_any)
  );

  assign clear_mask = ~(N'(1) << idx);
  assign req_ready  = alive && (state == IDLE);
  assign idx_valid  = (state == EMIT) && pending_any;
  assign idx_last   = (state == EMIT) && onehot_count_is_one(16'(pending));

  // alive keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_seen <= 1'b0;
      alive     <= 1'b0;
    end else begin
      alive     <= 1'b1;
      zero_seen <= 1'b0;
      case (state)
        IDLE: begin
          if (alive && req_valid) begin
            if (req == '0) begin
              zero_seen <= 1'b1;
            end else begin
              pending <= req;
              state   <= EMIT;
            end
          end
        end
        EMIT: begin
          if (flush) begin
            pending <= '0;
            state   <= IDLE;
          end else if (idx_ready) begin
            pending <= pending & clear_mask;
            if (idx_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb/tb_seq_priority_encoder.sv - self-checking bench for seq_priority_encoder
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req = 4'd0;
  logic       flush = 1'b0;
  logic       idx_valid;
  logic       idx_ready = 1'b0;
  logic [1:0] idx;
  logic       idx_last;
  logic       zero_seen;

  int checks = 0;
  int errors = 0;

  int  q[$];
  int  log_q[$];
  bit  m_alive = 0;
  bit  m_zero = 0;
  bit  cmp_en = 0;

  seq_priority_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .flush     (flush),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .zero_seen (zero_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of indices still owed to the consumer, ascending.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_alive = 0;
      m_zero  = 0;
    end else begin
      if (idx_valid && idx_ready) log_q.push_back(int'(idx));
      m_zero = 0;
      if (!m_alive) begin
        m_alive = 1;
      end else if (q.size() == 0) begin
        if (req_valid) begin
          if (req == 4'd0) m_zero = 1;
          else for (int i = 0; i < 4; i++) if (req[i]) q.push_back(i);
        end
      end else if (flush) begin
        q.delete();
      end else if (idx_ready) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", int'(req_ready), int'(m_alive && q.size() == 0));
      chk("idx_valid", int'(idx_valid), int'(q.size() != 0));
      chk("idx",       int'(idx),       (q.size() != 0) ? q[0] : 0);
      chk("idx_last",  int'(idx_last),  int'(q.size() == 1));
      chk("zero_seen", int'(zero_seen), int'(m_zero));
    end
  end

  task automatic send(input logic [3:0] v);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 1, 0);
    req = v;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk(name, log_q[i], exp[i]);
    log_q.delete();
  endtask

  initial begin
    // Reset state while rst_n is low.
    #2;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_idx_valid", int'(idx_valid), 0);
    chk("rst_idx",       int'(idx), 0);
    chk("rst_zero_seen", int'(zero_seen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);

    // Single bit.
    idx_ready = 1'b1;
    send(4'b0100);
    chk("single_idx", int'(idx), 2);
    chk("single_last", int'(idx_last), 1);
    @(negedge clk);
    chk("single_ready_next", int'(req_ready), 1);
    chk_log("single_log", '{2});

    // Multi-hot, one beat per cycle.
    send(4'b1011);
    @(negedge clk);
    @(negedge clk);
    chk("multi_last_beat", int'(idx), 3);
    chk("multi_last_flag", int'(idx_last), 1);
    @(negedge clk);
    chk("multi_ready", int'(req_ready), 1);
    chk_log("multi_log", '{0, 1, 3});

    // Backpressure holds the first beat.
    idx_ready = 1'b0;
    send(4'b0110);
    for (int i = 0; i < 5; i++) begin
      chk("bp_idx", int'(idx), 1);
      chk("bp_valid", int'(idx_valid), 1);
      @(negedge clk);
    end
    idx_ready = 1'b1;
    wait_idle();
    chk_log("bp_log", '{1, 2});

    // All-zero vector.
    send(4'b0000);
    chk("zero_pulse", int'(zero_seen), 1);
    chk("zero_valid", int'(idx_valid), 0);
    @(negedge clk);
    chk("zero_pulse_end", int'(zero_seen), 0);
    chk("zero_ready", int'(req_ready), 1);

    // Bit N-1 alone.
    send(4'b1000);
    chk("top_idx", int'(idx), 3);
    chk("top_last", int'(idx_last), 1);
    wait_idle();
    chk_log("top_log", '{3});

    // Flush together with the second handshake.
    send(4'b1111);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", int'(req_ready), 1);
    chk("flush_valid", int'(idx_valid), 0);
    repeat (3) @(negedge clk);
    chk_log("flush_log", '{0, 1});

    // Flush in IDLE does not block acceptance.
    flush = 1'b1;
    send(4'b0001);
    flush = 1'b0;
    chk("idle_flush_valid", int'(idx_valid), 1);
    wait_idle();
    chk_log("idle_flush_log", '{0});

    // Asynchronous reset mid-beat.
    idx_ready = 1'b0;
    send(4'b1100);
    chk("pre_rst_idx", int'(idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(idx_valid), 0);
    chk("async_ready", int'(req_ready), 0);
    chk("async_idx", int'(idx), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idx_ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", int'(req_ready), 1);
    repeat (3) @(negedge clk);
    chk("rel_valid", int'(idx_valid), 0);
    chk_log("rel_log", '{});

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
